multi_sprite_renderer: RTL and testbench
========================================

Name: multi_sprite_renderer

Overview:
- Parametrised successor to the single-frog/single-car VGA display block.
- Generates VGA timing and renders NUM_SPRITES solid square sprites over a programmable background, with fixed index priority.
- Positions are latched once per frame, so updates never tear mid-frame.
- Reports per-frame player-vs-sprite overlap (collision) to the game logic. Sits between game-state logic and the VGA pins.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch
- H_SYNC, 96, horizontal sync pulse width
- H_BACK, 48, horizontal back porch
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch
- V_SYNC, 2, vertical sync pulse width
- V_BACK, 33, vertical back porch
- NUM_SPRITES, 4, sprite slots (2..8); slot 0 is the player
- TILE_SIZE, 16, sprite edge length in pixels
- COLOR_BITS, 3, bits per colour channel

Ports:
- i_Clk  input  1  pixel clock
- i_Rst  input  1  synchronous, active-high reset
- i_Sprite_X  input  NUM_SPRITES*10  top-left X per slot; slot k occupies bits [10k+9:10k]
- i_Sprite_Y  input  NUM_SPRITES*10  top-left Y per slot, same packing
- i_Sprite_En  input  NUM_SPRITES  slot enable
- i_Sprite_Color  input  NUM_SPRITES*3*COLOR_BITS  per-slot {R,G,B}
- i_Bg_Color  input  3*COLOR_BITS  background {R,G,B}
- o_VGA_HSync  output  1  horizontal sync, active low
- o_VGA_VSync  output  1  vertical sync, active low
- o_VGA_Red  output  COLOR_BITS  red
- o_VGA_Grn  output  COLOR_BITS  green
- o_VGA_Blu  output  COLOR_BITS  blue
- o_Frame_Start  output  1  one-cycle pulse at the shadow-latch point
- o_Collision  output  NUM_SPRITES-1  bit k-1 set if slot 0 overlapped slot k during the last frame
- o_Collision_Valid  output  1  one-cycle pulse when o_Collision updates

Behaviour:
- Counters:
  - h counts 0..H_TOTAL-1 and wraps.
  - v increments when h wraps, and itself wraps at V_TOTAL-1.
  - H_TOTAL and V_TOTAL are the sums of the corresponding visible, front, sync and back parameters.
- Reset: h=v=0; syncs=1; colours=0; shadow enables=0; collision sticky bits=0; o_Collision=0; all pulses=0.
- Latch point is (h=0, v=V_VISIBLE), one cycle long. At that cycle:
  - Shadow X/Y/En/Color copy the inputs, with clamping: X>H_VISIBLE-TILE_SIZE becomes H_VISIBLE-TILE_SIZE; Y is clamped likewise against V_VISIBLE.
  - o_Frame_Start=1.
  - o_Collision<=sticky; o_Collision_Valid=1; sticky<=0.
- Between latch points, input changes have no visible effect.
- After reset, shadows stay disabled until the first latch point, so only background is drawn in the first frame.
- Clamp and hit comparisons use 11-bit arithmetic; no 10-bit overflow is allowed.
- Hit for slot k: En & (h>=X) & (h<X+TILE_SIZE) & (v>=Y) & (v<Y+TILE_SIZE) & visible, where visible = (h<H_VISIBLE & v<V_VISIBLE).
- Pipeline stage 1 registers:
  - the per-slot hit vector,
  - raw hsync (low for h in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC)),
  - raw vsync (same rule on v),
  - visible.
- Pipeline stage 2 registers:
  - Colour: lowest-index hit slot's colour; background if visible with no hit; 0 outside the visible area.
  - Stage-1 syncs, copied through.
- Latency: colour and syncs for counter position (h,v) appear exactly 2 cycles later, mutually aligned.
- Collision: in stage 1, if hit[0] & hit[k], set sticky[k-1]. Sticky is cleared only at the latch point. The latch point is in vblank, so set and clear never coincide.
- A disabled slot never hits, never draws and never collides. Slot 0 disabled means no collisions are reported.
- i_Rst asserted mid-frame: all state returns to reset values on the next edge; the pending sticky bits are discarded and no Valid pulse is issued.

Decomposition:
- Shared package vga_pkg: 640x480 timing constants, the H_TOTAL/V_TOTAL function, and the colour-triple packing helper.
- Sub-module sprite_hit_unit, one instance per slot: holds the shadow registers, clamping and the range compare, and outputs the hit bit and colour.
- The top level holds the counters, priority mux, sync pipeline and collision logic.

Test Plan:
- Reset, then run 2 frames -> hsync low for exactly 96 cycles per line, starting 2 cycles after h=656; vsync low for 2 lines starting at v=490; 800x525 cycles per frame.
- Slot 1 at (100,50), colour 3'b111/000/111, background 0 -> magenta for h 100..115 and v 50..65 (2-cycle lag), black elsewhere in the visible area.
- Slots 1 and 2 both at (200,200) with different colours -> slot 1 colour wins over the whole square.
- Slot 0 at X=630, Y=475 -> drawn at (624,464); nothing is drawn beyond h=639 or v=479.
- X changed mid-frame (v=100) -> the old position is drawn for the rest of the frame; the new position appears after the next o_Frame_Start.
- Slot 0 at (300,300), slot 2 at (310,310), slot 3 far away -> o_Collision=3'b010 with a Valid pulse at the next latch point. Separate the slots -> 3'b000 after one more frame.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA timing constants, the timing-total helper, the colour-triple packing
// helper, and the sync/visible bundle carried through the pixel pipeline.
package vga_pkg;

  localparam int unsigned VGA_H_VISIBLE = 640;
  localparam int unsigned VGA_H_FRONT   = 16;
  localparam int unsigned VGA_H_SYNC    = 96;
  localparam int unsigned VGA_H_BACK    = 48;
  localparam int unsigned VGA_V_VISIBLE = 480;
  localparam int unsigned VGA_V_FRONT   = 10;
  localparam int unsigned VGA_V_SYNC    = 2;
  localparam int unsigned VGA_V_BACK    = 33;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic visible;
  } sync_t;

  localparam sync_t SYNC_IDLE = '{hsync: 1'b1, vsync: 1'b1, visible: 1'b0};

  function automatic int unsigned timing_total(input int unsigned vis, input int unsigned fr,
                                               input int unsigned sy, input int unsigned bk);
    return vis + fr + sy + bk;
  endfunction

  // Packs {R,G,B} of cb bits each into the low 3*cb bits of the result.
  function automatic logic [23:0] rgb_pack(input logic [7:0] r, input logic [7:0] g,
                                           input logic [7:0] b, input int unsigned cb);
    logic [23:0] m;
    m = (24'd1 << cb) - 24'd1;
    return ((24'(r) & m) << (2 * cb)) | ((24'(g) & m) << cb) | (24'(b) & m);
  endfunction

endpackage

// File: rtl/multi_sprite_renderer_sprite_hit_unit.sv
// One sprite slot: frame-latched shadow position/enable/colour with edge clamping,
// and the combinational "does the current pixel fall inside this tile" compare.
module sprite_hit_unit
  import vga_pkg::*;
#(
  parameter int unsigned H_VISIBLE  = VGA_H_VISIBLE,
  parameter int unsigned V_VISIBLE  = VGA_V_VISIBLE,
  parameter int unsigned TILE_SIZE  = 16,
  parameter int unsigned COLOR_BITS = 3
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    latch_i,
  input  logic [9:0]              x_i,
  input  logic [9:0]              y_i,
  input  logic                    en_i,
  input  logic [3*COLOR_BITS-1:0] color_i,
  input  logic [10:0]             h_i,
  input  logic [10:0]             v_i,
  input  logic                    visible_i,
  output logic                    hit_o,
  output logic [3*COLOR_BITS-1:0] color_o
);

  localparam logic [10:0] X_MAX = 11'(H_VISIBLE - TILE_SIZE);
  localparam logic [10:0] Y_MAX = 11'(V_VISIBLE - TILE_SIZE);
  localparam logic [10:0] TILE  = 11'(TILE_SIZE);

  logic [10:0]             x_q, y_q, x_d, y_d;
  logic                    en_q;
  logic [3*COLOR_BITS-1:0] color_q;

  // Clamp in 11 bits so a far-right/bottom request still draws a whole tile on screen.
  always_comb begin
    x_d = {1'b0, x_i};
    y_d = {1'b0, y_i};
    if (x_d > X_MAX) x_d = X_MAX;
    if (y_d > Y_MAX) y_d = Y_MAX;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      x_q     <= '0;
      y_q     <= '0;
      en_q    <= 1'b0;
      color_q <= '0;
    end else if (latch_i) begin
      x_q     <= x_d;
      y_q     <= y_d;
      en_q    <= en_i;
      color_q <= color_i;
    end
  end

  assign hit_o = en_q && visible_i &&
                 (h_i >= x_q) && (h_i < x_q + TILE) &&
                 (v_i >= y_q) && (v_i < y_q + TILE);
  assign color_o = color_q;

endmodule

// File: rtl/multi_sprite_renderer.sv
// VGA timing generator plus NUM_SPRITES-slot square sprite renderer with fixed index
// priority, frame-latched positions and per-frame player collision reporting.
module multi_sprite_renderer
  import vga_pkg::*;
#(
  parameter int unsigned H_VISIBLE   = VGA_H_VISIBLE,
  parameter int unsigned H_FRONT     = VGA_H_FRONT,
  parameter int unsigned H_SYNC      = VGA_H_SYNC,
  parameter int unsigned H_BACK      = VGA_H_BACK,
  parameter int unsigned V_VISIBLE   = VGA_V_VISIBLE,
  parameter int unsigned V_FRONT     = VGA_V_FRONT,
  parameter int unsigned V_SYNC      = VGA_V_SYNC,
  parameter int unsigned V_BACK      = VGA_V_BACK,
  parameter int unsigned NUM_SPRITES = 4,
  parameter int unsigned TILE_SIZE   = 16,
  parameter int unsigned COLOR_BITS  = 3
) (
  input  logic                                i_Clk,
  input  logic                                i_Rst,
  input  logic [NUM_SPRITES*10-1:0]           i_Sprite_X,
  input  logic [NUM_SPRITES*10-1:0]           i_Sprite_Y,
  input  logic [NUM_SPRITES-1:0]              i_Sprite_En,
  input  logic [NUM_SPRITES*3*COLOR_BITS-1:0] i_Sprite_Color,
  input  logic [3*COLOR_BITS-1:0]             i_Bg_Color,
  output logic                                o_VGA_HSync,
  output logic                                o_VGA_VSync,
  output logic [COLOR_BITS-1:0]               o_VGA_Red,
  output logic [COLOR_BITS-1:0]               o_VGA_Grn,
  output logic [COLOR_BITS-1:0]               o_VGA_Blu,
  output logic                                o_Frame_Start,
  output logic [NUM_SPRITES-2:0]              o_Collision,
  output logic                                o_Collision_Valid
);

  localparam int unsigned CW      = 3 * COLOR_BITS;
  localparam int unsigned H_TOTAL = timing_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int unsigned V_TOTAL = timing_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS    = 11'(H_VISIBLE);
  localparam logic [10:0] V_VIS    = 11'(V_VISIBLE);
  localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] VS_START = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] VS_END   = 11'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [10:0]            h_q, v_q, h_d, v_d;
  logic                   latch, visible;
  sync_t                  raw, s1_q;
  logic [NUM_SPRITES-1:0] hit, hit_q;
  logic [CW-1:0]          slot_color [NUM_SPRITES];
  logic [CW-1:0]          bg_q, pix_q, pix_d;
  logic                   hs2_q, vs2_q;
  logic [NUM_SPRITES-2:0] sticky_q, sticky_d, coll_q;
  logic                   frame_start_q, coll_valid_q;

  always_comb begin
    h_d = h_q + 11'd1;
    v_d = v_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + 11'd1;
    end
  end

  assign latch   = (h_q == '0) && (v_q == V_VIS);
  assign visible = (h_q < H_VIS) && (v_q < V_VIS);

  always_comb begin
    raw.hsync   = !((h_q >= HS_START) && (h_q < HS_END));
    raw.vsync   = !((v_q >= VS_START) && (v_q < VS_END));
    raw.visible = visible;
  end

  for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_slot
    sprite_hit_unit #(
      .H_VISIBLE (H_VISIBLE),
      .V_VISIBLE (V_VISIBLE),
      .TILE_SIZE (TILE_SIZE),
      .COLOR_BITS(COLOR_BITS)
    ) u_slot (
      .clk_i    (i_Clk),
      .rst_i    (i_Rst),
      .latch_i  (latch),
      .x_i      (i_Sprite_X[10*g +: 10]),
      .y_i      (i_Sprite_Y[10*g +: 10]),
      .en_i     (i_Sprite_En[g]),
      .color_i  (i_Sprite_Color[CW*g +: CW]),
      .h_i      (h_q),
      .v_i      (v_q),
      .visible_i(visible),
      .hit_o    (hit[g]),
      .color_o  (slot_color[g])
    );
  end

  // Lowest-index hit wins; shadow colours are frame-stable so stage 2 can read them directly.
  always_comb begin
    logic found;
    found = 1'b0;
    pix_d = s1_q.visible ? bg_q : '0;
    for (int unsigned k = 0; k < NUM_SPRITES; k++) begin
      if (hit_q[k] && !found) begin
        pix_d = slot_color[k];
        found = 1'b1;
      end
    end
  end

  always_comb begin
    sticky_d = sticky_q;
    for (int unsigned k = 1; k < NUM_SPRITES; k++) begin
      if (hit[0] && hit[k]) sticky_d[k-1] = 1'b1;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      h_q           <= '0;
      v_q           <= '0;
      s1_q          <= SYNC_IDLE;
      hit_q         <= '0;
      hs2_q         <= 1'b1;
      vs2_q         <= 1'b1;
      pix_q         <= '0;
      bg_q          <= '0;
      sticky_q      <= '0;
      coll_q        <= '0;
      frame_start_q <= 1'b0;
      coll_valid_q  <= 1'b0;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      s1_q          <= raw;
      hit_q         <= hit;
      hs2_q         <= s1_q.hsync;
      vs2_q         <= s1_q.vsync;
      pix_q         <= pix_d;
      frame_start_q <= latch;
      coll_valid_q  <= latch;
      // Latch point sits in vblank, so no hit can be lost by clearing here.
      if (latch) begin
        bg_q     <= i_Bg_Color;
        coll_q   <= sticky_q;
        sticky_q <= '0;
      end else begin
        sticky_q <= sticky_d;
      end
    end
  end

  assign o_VGA_HSync       = hs2_q;
  assign o_VGA_VSync       = vs2_q;
  assign o_VGA_Red         = pix_q[CW-1 -: COLOR_BITS];
  assign o_VGA_Grn         = pix_q[2*COLOR_BITS-1 -: COLOR_BITS];
  assign o_VGA_Blu         = pix_q[COLOR_BITS-1:0];
  assign o_Frame_Start     = frame_start_q;
  assign o_Collision       = coll_q;
  assign o_Collision_Valid = coll_valid_q;

endmodule

// File: tb/tb_multi_sprite_renderer.sv
// Bench for multi_sprite_renderer on a shrunken raster: per-cycle reference model,
// a table of probed pixels/collisions, and hand-written mid-frame sequences.
module tb_multi_sprite_renderer;
  import vga_pkg::*;

  localparam int HV = 48, HF = 4, HS = 8, HB = 4;
  localparam int VV = 32, VF = 2, VS = 2, VB = 2;
  localparam int NS = 4, T = 8, CB = 3;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int LATCH = VV * HT;

  localparam logic [8:0] C0 = 9'o770, C1 = 9'o707, C2 = 9'o070, C3 = 9'o007;

  logic        clk, rst;
  logic [39:0] sx, sy;
  logic [3:0]  en;
  logic [35:0] scol;
  logic [8:0]  bg;
  logic        hs, vs, fs, cv;
  logic [2:0]  r, g, b, coll;

  multi_sprite_renderer #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .NUM_SPRITES(NS), .TILE_SIZE(T), .COLOR_BITS(CB)
  ) dut (
    .i_Clk(clk), .i_Rst(rst),
    .i_Sprite_X(sx), .i_Sprite_Y(sy), .i_Sprite_En(en),
    .i_Sprite_Color(scol), .i_Bg_Color(bg),
    .o_VGA_HSync(hs), .o_VGA_VSync(vs),
    .o_VGA_Red(r), .o_VGA_Grn(g), .o_VGA_Blu(b),
    .o_Frame_Start(fs), .o_Collision(coll), .o_Collision_Valid(cv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  int n_chk = 0, n_err = 0;

  // ---------------- reference model ----------------
  typedef struct packed {
    logic       hs;
    logic       vs;
    logic [8:0] rgb;
  } exp_t;

  int         k;
  int         mx [NS];
  int         my [NS];
  bit         men [NS];
  logic [8:0] mc [NS];
  logic [8:0] mbg;
  logic [2:0] msticky, mcoll;
  exp_t       pq[$];
  exp_t       e_cur;
  bit         fs_e;

  task automatic model_step(input int kk);
    int   h, v, x, y;
    bit   vis;
    bit   hitv [NS];
    exp_t e;
    h = kk % HT;
    v = (kk / HT) % VT;
    if (kk % FRAME == LATCH) begin
      mcoll   = msticky;
      msticky = '0;
      mbg     = bg;
      for (int p = 0; p < NS; p++) begin
        x = int'(sx[10*p +: 10]);
        y = int'(sy[10*p +: 10]);
        mx[p]  = (x > HV - T) ? HV - T : x;
        my[p]  = (y > VV - T) ? VV - T : y;
        men[p] = en[p];
        mc[p]  = scol[9*p +: 9];
      end
    end
    vis   = (h < HV) && (v < VV);
    e.hs  = !((h >= HV + HF) && (h < HV + HF + HS));
    e.vs  = !((v >= VV + VF) && (v < VV + VF + VS));
    e.rgb = vis ? mbg : 9'd0;
    for (int p = 0; p < NS; p++)
      hitv[p] = men[p] && vis && (h >= mx[p]) && (h < mx[p] + T) && (v >= my[p]) && (v < my[p] + T);
    for (int p = NS - 1; p >= 0; p--)
      if (hitv[p]) e.rgb = mc[p];
    for (int p = 1; p < NS; p++)
      if (hitv[0] && hitv[p]) msticky[p-1] = 1'b1;
    pq.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      k = -1;
      pq.delete();
      msticky = '0;
      mcoll   = '0;
      mbg     = '0;
      for (int p = 0; p < NS; p++) begin
        men[p] = 1'b0; mx[p] = 0; my[p] = 0; mc[p] = '0;
      end
    end else begin
      k++;
      if (k >= 2) e_cur = pq.pop_front();
      else        e_cur = {1'b1, 1'b1, 9'd0};
      fs_e = (k >= 1) && ((k - 1) % FRAME == LATCH);
      n_chk++;
      if ({hs, vs, r, g, b} !== {e_cur.hs, e_cur.vs, e_cur.rgb} || fs !== fs_e || cv !== fs_e || coll !== mcoll) begin
        n_err++;
        $display("FAIL cycle k=%0d got hs=%b vs=%b rgb=%o fs=%b cv=%b coll=%b want hs=%b vs=%b rgb=%o fs=%b cv=%b coll=%b",
                 k, hs, vs, {r, g, b}, fs, cv, coll, e_cur.hs, e_cur.vs, e_cur.rgb, fs_e, fs_e, mcoll);
      end
      model_step(k);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_fs(input string tag);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (fs !== 1'b1 && n < 2 * FRAME);
    if (fs !== 1'b1) begin
      n_chk++;
      n_err++;
      $display("FAIL %s frame-start timeout got fs=%b want 1", tag, fs);
    end
  endtask

  task automatic check_coll(input logic [2:0] want, input string tag);
    wait_fs(tag);
    n_chk++;
    if (coll !== want || cv !== 1'b1) begin
      n_err++;
      $display("FAIL %s collision got coll=%b valid=%b want coll=%b valid=1", tag, coll, cv, want);
    end
  endtask

  // Output currently on the pins belongs to position k-1 (k still holds the previous cycle).
  task automatic probe(input int ph, input int pv, input logic [8:0] want, input string tag);
    int n;
    bit at;
    n  = 0;
    at = 1'b0;
    while (!at && n < 2 * FRAME) begin
      tick();
      n++;
      at = (k >= 1) && ((k - 1) % HT == ph) && (((k - 1) / HT) % VT == pv);
    end
    n_chk++;
    if (!at) begin
      n_err++;
      $display("FAIL %s probe (%0d,%0d) timeout", tag, ph, pv);
    end else if ({r, g, b} !== want) begin
      n_err++;
      $display("FAIL %s pixel (%0d,%0d) got rgb=%o want rgb=%o", tag, ph, pv, {r, g, b}, want);
    end
  endtask

  task automatic set_slot(input int p, input int x, input int y);
    sx[10*p +: 10] = 10'(x);
    sy[10*p +: 10] = 10'(y);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int         x0, y0, x1, y1, x2, y2, x3, y3;
    logic [3:0] en;
    logic [8:0] bg;
    int         ph, pv;
    logic [8:0] want;
    logic [2:0] coll;
  } vec_t;

  vec_t vq[$];

  task automatic add(input int x0, input int y0, input int x1, input int y1,
                     input int x2, input int y2, input int x3, input int y3,
                     input logic [3:0] e, input logic [8:0] bgc,
                     input int ph, input int pv, input logic [8:0] w, input logic [2:0] c);
    vec_t t;
    t.x0 = x0; t.y0 = y0; t.x1 = x1; t.y1 = y1;
    t.x2 = x2; t.y2 = y2; t.x3 = x3; t.y3 = y3;
    t.en = e; t.bg = bgc; t.ph = ph; t.pv = pv; t.want = w; t.coll = c;
    vq.push_back(t);
  endtask

  logic [2:0] prev_coll;

  initial begin
    rst  = 1'b1;
    sx   = '0;
    sy   = '0;
    en   = '0;
    bg   = '0;
    scol = {C3, C2, C1, C0};

    //   x0  y0    x1 y1  x2 y2  x3 y3  en       bg      probe    want  coll
    add(0,   0,    10, 5,  0, 0,  0, 0, 4'b0010, 9'o000, 10, 5,   C1, 3'b000);
    add(0,   0,    10, 5,  0, 0,  0, 0, 4'b0010, 9'o000, 17, 12,  C1, 3'b000);
    add(0,   0,    10, 5,  0, 0,  0, 0, 4'b0010, 9'o000, 18, 12,  '0, 3'b000);
    add(0,   0,    10, 5,  0, 0,  0, 0, 4'b0010, 9'o000, 17, 13,  '0, 3'b000);
    add(0,   0,    20, 20, 20, 20, 0, 0, 4'b0110, 9'o000, 20, 20, C1, 3'b000);
    add(0,   0,    20, 20, 20, 20, 0, 0, 4'b0110, 9'o000, 27, 27, C1, 3'b000);
    add(45,  33,   0, 0,  0, 0,  0, 0, 4'b0001, 9'o000, 40, 24,  C0, 3'b000);
    add(45,  33,   0, 0,  0, 0,  0, 0, 4'b0001, 9'o000, 47, 31,  C0, 3'b000);
    add(45,  33,   0, 0,  0, 0,  0, 0, 4'b0001, 9'o000, 39, 24,  '0, 3'b000);
    add(1000, 1000, 0, 0, 0, 0,  0, 0, 4'b0001, 9'o000, 47, 31,  C0, 3'b000);
    add(10,  10,   0, 0,  15, 15, 0, 0, 4'b1101, 9'o000, 15, 15, C0, 3'b010);
    add(10,  10,   0, 0,  40, 0,  0, 0, 4'b1101, 9'o000, 2, 2,   C3, 3'b000);
    add(10,  10,   14, 14, 30, 20, 0, 0, 4'b0111, 9'o000, 14, 14, C0, 3'b001);
    add(10,  10,   10, 10, 30, 20, 0, 0, 4'b0110, 9'o000, 10, 10, C1, 3'b000);
    add(0,   0,    0, 0,  0, 0,  0, 0, 4'b0000, 9'o123, 5, 5,    9'o123, 3'b000);
    add(0,   0,    0, 0,  0, 0,  0, 0, 4'b0000, 9'o123, 50, 5,   '0, 3'b000);
    add(0,   0,    0, 0,  0, 0,  0, 0, 4'b0000, 9'o123, 5, 33,   '0, 3'b000);

    repeat (3) tick();
    rst = 1'b0;

    // First frame after reset draws background only, so the first report is empty.
    prev_coll = 3'b000;
    foreach (vq[i]) begin
      set_slot(0, vq[i].x0, vq[i].y0);
      set_slot(1, vq[i].x1, vq[i].y1);
      set_slot(2, vq[i].x2, vq[i].y2);
      set_slot(3, vq[i].x3, vq[i].y3);
      en = vq[i].en;
      bg = vq[i].bg;
      check_coll(prev_coll, $sformatf("tbl%0d_coll", i));
      probe(vq[i].ph, vq[i].pv, vq[i].want, $sformatf("tbl%0d", i));
      prev_coll = vq[i].coll;
    end
    check_coll(prev_coll, "tbl_last_coll");

    // Mid-frame position change must not tear.
    bg = '0;
    en = 4'b0010;
    set_slot(1, 10, 5);
    wait_fs("move0");
    probe(10, 8, C1, "move_before");
    probe(0, 10, '0, "move_row10");
    set_slot(1, 30, 5);
    probe(10, 12, C1, "move_old_kept");
    probe(30, 12, '0, "move_new_hidden");
    wait_fs("move1");
    probe(10, 5, '0, "move_old_gone");
    probe(30, 5, C1, "move_new_shown");

    // Reset mid-frame after an overlap: pending collision is discarded.
    en = 4'b0101;
    set_slot(0, 10, 10);
    set_slot(2, 12, 12);
    wait_fs("rst0");
    probe(0, 20, '0, "rst_pre");
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    check_coll(3'b000, "rst_discard");
    check_coll(3'b010, "rst_after");

    // Randomised traffic, including mid-frame input churn, against the model.
    for (int n = 0; n < 3 * FRAME; n++) begin
      if (n % 300 == 0) begin
        for (int p = 0; p < NS; p++) begin
          set_slot(p, int'($urandom_range(0, 60)), int'($urandom_range(0, 40)));
          scol[9*p +: 9] = 9'(rgb_pack(8'($urandom_range(0, 7)), 8'($urandom_range(0, 7)),
                                       8'($urandom_range(0, 7)), CB));
        end
        en = 4'($urandom_range(0, 15));
        bg = 9'($urandom_range(0, 511));
      end
      tick();
    end
    repeat (4) tick();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
